// File: rtl/riscv_pipe_skid_buffer_pkg.sv
// Shared definitions for the elastic pipeline stage: data width, bundle
// size and the state encoding reused by other elastic stages.
package riscv_pipe_skid_buffer_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NWORDS = 6;
  localparam int unsigned OCC_W  = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  // Number of bundles held in a given state.
  function automatic logic [OCC_W-1:0] state_occupancy(input skid_state_e s);
    case (s)
      ST_BUSY: state_occupancy = OCC_W'(1);
      ST_FULL: state_occupancy = OCC_W'(2);
      default: state_occupancy = OCC_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/riscv_pipe_word_bank.sv
// One bank of NWORDS x WIDTH registers with a common load enable.
// Ports: i_clk, i_rstn (async active-low, resets to REGISTER_INIT),
//        i_load (capture i_data), i_data / o_data (bundle words).
module riscv_pipe_word_bank
  import riscv_pipe_skid_buffer_pkg::*;
#(
  parameter int unsigned      WIDTH         = XLEN,
  parameter logic [WIDTH-1:0] REGISTER_INIT = '0
) (
  input  logic                          i_clk,
  input  logic                          i_rstn,
  input  logic                          i_load,
  input  logic [NWORDS-1:0][WIDTH-1:0]  i_data,
  output logic [NWORDS-1:0][WIDTH-1:0]  o_data
);

  logic [NWORDS-1:0][WIDTH-1:0] r_words;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_words <= {NWORDS{REGISTER_INIT}};
    end else if (i_load) begin
      r_words <= i_data;
    end
  end

  assign o_data = r_words;

endmodule

// File: rtl/riscv_pipe_skid_buffer.sv
// Two-entry elastic pipeline stage (main + skid) carrying six words with
// valid/ready on both sides and a synchronous flush.
// Ports: i_clk, i_rstn (async active-low), i_flush (squash held bundles),
//        i_valid/o_ready/i_data_0..5 (upstream), o_valid/i_ready/o_data_0..5
//        (downstream, from main entry), o_occupancy (bundles held).
module riscv_pipe_skid_buffer
  import riscv_pipe_skid_buffer_pkg::*;
#(
  parameter int unsigned      WIDTH         = XLEN,
  parameter logic [WIDTH-1:0] REGISTER_INIT = '0
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data_0,
  input  logic [WIDTH-1:0] i_data_1,
  input  logic [WIDTH-1:0] i_data_2,
  input  logic [WIDTH-1:0] i_data_3,
  input  logic [WIDTH-1:0] i_data_4,
  input  logic [WIDTH-1:0] i_data_5,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data_0,
  output logic [WIDTH-1:0] o_data_1,
  output logic [WIDTH-1:0] o_data_2,
  output logic [WIDTH-1:0] o_data_3,
  output logic [WIDTH-1:0] o_data_4,
  output logic [WIDTH-1:0] o_data_5,
  output logic [OCC_W-1:0] o_occupancy
);

  skid_state_e r_state;
  skid_state_e w_state_nxt;

  logic w_in_fire;
  logic w_out_fire;
  logic w_main_load;
  logic w_skid_load;
  logic w_main_from_skid;

  logic [NWORDS-1:0][WIDTH-1:0] w_in_words;
  logic [NWORDS-1:0][WIDTH-1:0] w_main_d;
  logic [NWORDS-1:0][WIDTH-1:0] w_main_q;
  logic [NWORDS-1:0][WIDTH-1:0] w_skid_q;

  assign w_in_words = {i_data_5, i_data_4, i_data_3, i_data_2, i_data_1, i_data_0};

  // Handshake status is decoded purely from the state register.
  assign o_ready     = (r_state != ST_FULL);
  assign o_valid     = (r_state != ST_EMPTY);
  assign o_occupancy = state_occupancy(r_state);

  assign w_in_fire  = i_valid & o_ready;
  assign w_out_fire = o_valid & i_ready;

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and bank enables; flush overrides everything and drops loads.
  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_skid_load      = 1'b0;
    w_main_from_skid = 1'b0;
    if (i_flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_main_load = 1'b1;
            w_state_nxt = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_in_fire && w_out_fire) begin
            w_main_load = 1'b1;
          end else if (w_in_fire) begin
            // Downstream stalled: park the in-flight bundle in the skid entry.
            w_skid_load = 1'b1;
            w_state_nxt = ST_FULL;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_state_nxt      = ST_BUSY;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : w_in_words;

  riscv_pipe_word_bank #(
    .WIDTH         (WIDTH),
    .REGISTER_INIT (REGISTER_INIT)
  ) u_main_bank (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_load (w_main_load),
    .i_data (w_main_d),
    .o_data (w_main_q)
  );

  riscv_pipe_word_bank #(
    .WIDTH         (WIDTH),
    .REGISTER_INIT (REGISTER_INIT)
  ) u_skid_bank (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_load (w_skid_load),
    .i_data (w_in_words),
    .o_data (w_skid_q)
  );

  assign o_data_0 = w_main_q[0];
  assign o_data_1 = w_main_q[1];
  assign o_data_2 = w_main_q[2];
  assign o_data_3 = w_main_q[3];
  assign o_data_4 = w_main_q[4];
  assign o_data_5 = w_main_q[5];

endmodule

// File: tb/tb_riscv_pipe_skid_buffer.sv
// Scoreboard bench for riscv_pipe_skid_buffer: a two-deep FIFO reference
// model (a queue) predicts handshakes and data; a monitor checks outputs.
module tb_riscv_pipe_skid_buffer;

  localparam int unsigned W    = 32;
  localparam logic [W-1:0] INIT = 32'hDEAD_BEEF;

  typedef logic [5:0][W-1:0] bundle_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         dut_ready;
  logic         dut_valid;
  logic [1:0]   dut_occ;
  bundle_t      drv;
  logic [W-1:0] od0, od1, od2, od3, od4, od5;

  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;

  // Bundles accepted by the stage and not yet delivered, oldest first.
  bundle_t sb_q[$];

  always #5 clk = ~clk;

  riscv_pipe_skid_buffer #(
    .WIDTH         (W),
    .REGISTER_INIT (INIT)
  ) dut (
    .i_clk       (clk),
    .i_rstn      (rst_n),
    .i_flush     (flush),
    .i_valid     (in_valid),
    .o_ready     (dut_ready),
    .i_data_0    (drv[0]),
    .i_data_1    (drv[1]),
    .i_data_2    (drv[2]),
    .i_data_3    (drv[3]),
    .i_data_4    (drv[4]),
    .i_data_5    (drv[5]),
    .o_valid     (dut_valid),
    .i_ready     (out_ready),
    .o_data_0    (od0),
    .o_data_1    (od1),
    .o_data_2    (od2),
    .o_data_3    (od3),
    .o_data_4    (od4),
    .o_data_5    (od5),
    .o_occupancy (dut_occ)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bundle_t out_bundle();
    bundle_t b;
    b[0] = od0; b[1] = od1; b[2] = od2; b[3] = od3; b[4] = od4; b[5] = od5;
    return b;
  endfunction

  // Monitor: compare outputs to the model mid-cycle; retire on out_fire.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        bundle_t got;
        got = out_bundle();
        check("o_valid", W'(dut_valid), W'(sb_q.size() > 0));
        check("o_ready", W'(dut_ready), W'(sb_q.size() < 2));
        check("o_occupancy", W'(dut_occ), W'(sb_q.size()));
        if (sb_q.size() > 0) begin
          for (int w = 0; w < 6; w++) check($sformatf("o_data_%0d", w), got[w], sb_q[0][w]);
          if (out_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  // One clock of stimulus; the model records what the stage should accept.
  task automatic cycle(input logic v, input logic r, input logic f, input logic [W-1:0] d0);
    bit acc;
    bundle_t b;
    @(negedge clk);
    b[0] = d0;
    for (int w = 1; w < 6; w++) b[w] = W'($urandom);
    drv       = b;
    in_valid  = v;
    out_ready = r;
    flush     = f;
    acc = v && (sb_q.size() < 2) && !f;
    @(posedge clk);
    #1;
    if (f) sb_q.delete();
    else if (acc) sb_q.push_back(b);
  endtask

  task automatic check_reset_outputs(input string tag);
    bundle_t got;
    got = out_bundle();
    check({tag, "_valid"}, W'(dut_valid), W'(0));
    check({tag, "_ready"}, W'(dut_ready), W'(1));
    check({tag, "_occ"}, W'(dut_occ), W'(0));
    for (int w = 0; w < 6; w++) check($sformatf("%s_data_%0d", tag, w), got[w], INIT);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    drv = '0;
    #12;
    check_reset_outputs("rst0");
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Streaming with no backpressure.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b1, 1'b0, W'(i));
    cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, '0);

    // Backpressure: A, B absorbed, C refused, then drain in order.
    cycle(1'b1, 1'b0, 1'b0, 32'hA);
    cycle(1'b1, 1'b0, 1'b0, 32'hB);
    cycle(1'b1, 1'b0, 1'b0, 32'hC);
    cycle(1'b1, 1'b0, 1'b0, 32'hC);
    // FULL with i_valid and i_ready together: skid moves up, C not taken.
    cycle(1'b1, 1'b1, 1'b0, 32'hC);
    cycle(1'b1, 1'b1, 1'b0, 32'hC);
    cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, '0);

    // Flush in BUSY with a simultaneous in_fire.
    cycle(1'b1, 1'b0, 1'b0, 32'h11);
    cycle(1'b1, 1'b0, 1'b1, 32'h22);
    cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, 32'h33);
    cycle(1'b0, 1'b1, 1'b0, '0);

    // Reset asynchronously while FULL.
    cycle(1'b1, 1'b0, 1'b0, 32'h44);
    cycle(1'b1, 1'b0, 1'b0, 32'h55);
    cycle(1'b0, 1'b0, 1'b0, '0);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    sb_q.delete();
    @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    cycle(1'b1, 1'b1, 1'b0, 32'h66);
    cycle(1'b0, 1'b1, 1'b0, '0);

    // Random valid/ready/flush.
    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 63) == 0), W'($urandom));
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, '0);
    check("drained", W'(sb_q.size()), W'(0));

    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
